// File: rtl/dsp_mac_sequencer.sv
// Sequencing controller for one 18x18 DSP multiply-accumulate slice: streams a job of
// operand pairs into the slice, schedules opmode/enables, and returns the 48-bit result.
module dsp_mac_sequencer #(
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             sub,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [17:0]      in_a,
   input  logic [17:0]      in_b,
   output logic [17:0]      dsp_a,
   output logic [17:0]      dsp_b,
   output logic             dsp_cea,
   output logic             dsp_ceb,
   output logic             dsp_cem,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_ceopmode,
   output logic             dsp_cep,
   input  logic [47:0]      dsp_p,
   input  logic             dsp_carryout,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [47:0]      res_data,
   output logic             res_carry
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state, state_next;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] issued;
   logic             sub_q;
   logic [1:0]       drain_cnt;
   logic             tag_v1;
   logic             tag_v2;
   logic             cep_d;
   logic             fire;
   logic             last_fire;
   logic             accept_job;
   logic             accept_empty;

   assign fire         = in_valid & in_ready;
   assign last_fire    = fire & (issued == (len_q - LEN_W'(1)));
   assign accept_job   = (state == IDLE) & start & (len != {LEN_W{1'b0}});
   assign accept_empty = (state == IDLE) & start & (len == {LEN_W{1'b0}});

   assign busy         = (state != IDLE);
   assign in_ready     = (state == RUN);
   assign res_valid    = (state == DONE);
   assign dsp_a        = in_a;
   assign dsp_b        = in_b;
   assign dsp_cea      = fire;
   assign dsp_ceb      = fire;
   assign dsp_cem      = busy;
   assign dsp_ceopmode = tag_v1;
   assign dsp_cep      = tag_v2;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept_job) begin
               state_next = RUN;
            end else if (accept_empty) begin
               state_next = DONE;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (last_fire) begin
               state_next = DRAIN;
            end else begin
               state_next = RUN;
            end
         end
         DRAIN: begin
            if (drain_cnt == 2'd0) begin
               state_next = DONE;
            end else begin
               state_next = DRAIN;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_next = IDLE;
            end else begin
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Job parameters, issue count and drain countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q     <= {LEN_W{1'b0}};
         sub_q     <= 1'b0;
         issued    <= {LEN_W{1'b0}};
         drain_cnt <= 2'd0;
      end else begin
         if (accept_job) begin
            len_q  <= len;
            sub_q  <= sub;
            issued <= {LEN_W{1'b0}};
         end else if (fire) begin
            issued <= issued + LEN_W'(1);
         end
         if (last_fire) begin
            drain_cnt <= 2'd2;
         end else if ((state == DRAIN) && (drain_cnt != 2'd0)) begin
            drain_cnt <= drain_cnt - 2'd1;
         end
      end
   end

   // Opmode register and valid tag pipeline; the first product of a job uses Z=0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dsp_opmode <= 8'h00;
         tag_v1     <= 1'b0;
         tag_v2     <= 1'b0;
         cep_d      <= 1'b0;
      end else begin
         if (fire) begin
            dsp_opmode <= {sub_q, 3'b000, (issued != {LEN_W{1'b0}}), 3'b001};
         end
         tag_v1 <= fire;
         tag_v2 <= tag_v1;
         cep_d  <= tag_v2;
      end
   end

   // Result capture and carry accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_data  <= 48'd0;
         res_carry <= 1'b0;
      end else begin
         if (accept_empty) begin
            res_data <= 48'd0;
         end else if ((state == DRAIN) && (drain_cnt == 2'd0)) begin
            res_data <= dsp_p;
         end
         if (accept_job || accept_empty) begin
            res_carry <= 1'b0;
         end else if (cep_d) begin
            res_carry <= res_carry | dsp_carryout;
         end
      end
   end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural slice model, directed jobs, and a scoreboard
// whose monitor checks every result handshake against hand-computed values.
module tb_dsp_mac_sequencer;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [7:0]         len;
   logic               sub;
   logic               busy;
   logic               in_valid;
   logic               in_ready;
   logic signed [17:0] in_a;
   logic signed [17:0] in_b;
   logic [17:0]        dsp_a;
   logic [17:0]        dsp_b;
   logic               dsp_cea;
   logic               dsp_ceb;
   logic               dsp_cem;
   logic [7:0]         dsp_opmode;
   logic               dsp_ceopmode;
   logic               dsp_cep;
   logic [47:0]        dsp_p;
   logic               dsp_carryout;
   logic               res_valid;
   logic               res_ready;
   logic [47:0]        res_data;
   logic               res_carry;

   int checks   = 0;
   int failures = 0;
   logic [48:0] sb[$];

   always #5 clk = ~clk;

   dsp_mac_sequencer #(.LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len), .sub(sub), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
      .dsp_cem(dsp_cem), .dsp_opmode(dsp_opmode), .dsp_ceopmode(dsp_ceopmode),
      .dsp_cep(dsp_cep), .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_carry(res_carry)
   );

   // Slice model: A1/B1, M, OPMODE and P/CARRYOUT registers
   logic signed [17:0] a1 = 18'sd0;
   logic signed [17:0] b1 = 18'sd0;
   logic signed [35:0] m_r = 36'sd0;
   logic [7:0]         opm = 8'h00;
   logic [47:0]        p_r = 48'd0;
   logic               co_r = 1'b0;
   logic [47:0]        xv, zv;
   logic [48:0]        sum49;

   assign xv    = (opm[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
   assign zv    = (opm[3:2] == 2'b10) ? p_r : 48'd0;
   assign sum49 = opm[7] ? ({1'b0, zv} - {1'b0, xv}) : ({1'b0, zv} + {1'b0, xv});
   assign dsp_p        = p_r;
   assign dsp_carryout = co_r;

   always @(posedge clk) begin
      if (dsp_cea) a1 <= dsp_a;
      if (dsp_ceb) b1 <= dsp_b;
      if (dsp_cem) m_r <= a1 * b1;
      if (dsp_ceopmode) opm <= dsp_opmode;
      if (dsp_cep) begin
         p_r  <= sum49[47:0];
         co_r <= sum49[48];
      end
   end

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sb_push(input logic [47:0] d, input logic c);
      sb.push_back({c, d});
   endtask

   // Monitor: every result handshake must match the oldest expected entry
   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%h expected=none", res_data);
         end else begin
            logic [48:0] e;
            e = sb.pop_front();
            chk("res_data", res_data, e[47:0]);
            chk("res_carry", {47'd0, res_carry}, {47'd0, e[48]});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [7:0] l, input logic s);
      start = 1'b1;
      len   = l;
      sub   = s;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_drained(input string name);
      int n = 0;
      while ((sb.size() != 0) && (n < 30)) begin
         tick();
         n++;
      end
      chk(name, 48'(sb.size()), 48'd0);
   endtask

   int j1a[3] = '{2, 4, -1};
   int j1b[3] = '{3, 5, 7};
   logic [7:0] j1op[4] = '{8'h00, 8'h01, 8'h09, 8'h09};

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; len = 8'd0; sub = 1'b0;
      in_valid = 1'b0; in_a = 18'sd0; in_b = 18'sd0; res_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {47'd0, busy}, 48'd0);
      chk("rst_in_ready", {47'd0, in_ready}, 48'd0);
      chk("rst_cem", {47'd0, dsp_cem}, 48'd0);
      chk("rst_cep", {47'd0, dsp_cep}, 48'd0);
      chk("rst_ceopmode", {47'd0, dsp_ceopmode}, 48'd0);
      chk("rst_res_valid", {47'd0, res_valid}, 48'd0);
      chk("rst_res_carry", {47'd0, res_carry}, 48'd0);
      chk("rst_opmode", {40'd0, dsp_opmode}, 48'd0);
      chk("rst_res_data", res_data, 48'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // len=3 back-to-back: 6+20-7 = 19, final add wraps past 2^48
      sb_push(48'd19, 1'b1);
      start_job(8'd3, 1'b0);
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_valid = (cyc < 3);
         in_a = (cyc < 3) ? 18'(j1a[cyc]) : 18'sd0;
         in_b = (cyc < 3) ? 18'(j1b[cyc]) : 18'sd0;
         @(negedge clk);
         chk("j1_cep", {47'd0, dsp_cep}, {47'd0, (cyc >= 2 && cyc <= 4)});
         chk("j1_ceopmode", {47'd0, dsp_ceopmode}, {47'd0, (cyc >= 1 && cyc <= 3)});
         chk("j1_res_valid", {47'd0, res_valid}, {47'd0, (cyc == 6)});
         if (cyc >= 1 && cyc <= 3) chk("j1_opmode", {40'd0, dsp_opmode}, {40'd0, j1op[cyc]});
         if (cyc == 7) chk("j1_busy_after", {47'd0, busy}, 48'd0);
         tick();
      end

      // len=2 sub with a 2-cycle bubble: -(100+5) = -105
      sb_push(48'hFFFF_FFFF_FF97, 1'b1);
      start_job(8'd2, 1'b1);
      for (int cyc = 0; cyc < 9; cyc++) begin
         in_valid = (cyc == 0) || (cyc == 3);
         in_a = (cyc == 0) ? 18'sd10 : 18'sd1;
         in_b = (cyc == 0) ? 18'sd10 : 18'sd5;
         @(negedge clk);
         chk("j2_cep", {47'd0, dsp_cep}, {47'd0, (cyc == 2) || (cyc == 5)});
         chk("j2_res_valid", {47'd0, res_valid}, {47'd0, (cyc == 7)});
         if (cyc == 3) chk("j2_opmode_first", {40'd0, dsp_opmode}, 48'h81);
         if (cyc == 4) chk("j2_opmode_next", {40'd0, dsp_opmode}, 48'h89);
         tick();
      end

      // len=0: immediate empty result, no slice enables
      sb_push(48'd0, 1'b0);
      in_valid = 1'b1;
      in_a = 18'sd5;
      in_b = 18'sd5;
      start_job(8'd0, 1'b0);
      @(negedge clk);
      chk("j3_res_valid", {47'd0, res_valid}, 48'd1);
      chk("j3_cea", {47'd0, dsp_cea}, 48'd0);
      chk("j3_cep", {47'd0, dsp_cep}, 48'd0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("j3_busy_after", {47'd0, busy}, 48'd0);
      chk("j3_cep_after", {47'd0, dsp_cep}, 48'd0);
      tick();

      // len=1 with result back-pressure: -3*4 = -12
      res_ready = 1'b0;
      sb_push(48'hFFFF_FFFF_FFF4, 1'b0);
      start_job(8'd1, 1'b0);
      in_valid = 1'b1;
      in_a = -18'sd3;
      in_b = 18'sd4;
      tick();
      in_valid = 1'b0;
      begin
         int n = 0;
         while (!res_valid && (n < 20)) begin
            tick();
            n++;
         end
      end
      chk("j4_valid_seen", {47'd0, res_valid}, 48'd1);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         len = 8'd0;
         @(negedge clk);
         chk("j4_hold_data", res_data, 48'hFFFF_FFFF_FFF4);
         chk("j4_hold_busy", {47'd0, busy}, 48'd1);
         chk("j4_hold_valid", {47'd0, res_valid}, 48'd1);
         tick();
      end
      start = 1'b0;
      res_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("j4_busy_after", {47'd0, busy}, 48'd0);
      chk("j4_valid_after", {47'd0, res_valid}, 48'd0);
      tick();

      // Abort a len=4 job after two fires, then run len=1 (3,3) = 9
      start_job(8'd4, 1'b0);
      in_valid = 1'b1;
      in_a = 18'sd1;
      in_b = 18'sd1;
      tick();
      in_a = 18'sd2;
      in_b = 18'sd2;
      tick();
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {47'd0, busy}, 48'd0);
      chk("abort_in_ready", {47'd0, in_ready}, 48'd0);
      chk("abort_cep", {47'd0, dsp_cep}, 48'd0);
      chk("abort_ceopmode", {47'd0, dsp_ceopmode}, 48'd0);
      chk("abort_opmode", {40'd0, dsp_opmode}, 48'd0);
      tick();
      rst_n = 1'b1;
      tick();
      sb_push(48'd9, 1'b0);
      start_job(8'd1, 1'b0);
      in_valid = 1'b1;
      in_a = 18'sd3;
      in_b = 18'sd3;
      tick();
      in_valid = 1'b0;
      wait_drained("j5_result_timeout");
      tick();
      chk("sb_empty", 48'(sb.size()), 48'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Sequencing controller for the 18x18 DSP multiply-accumulate slice. It accepts a job of `len` operand pairs, streams them into the slice's A/B ports over a valid/ready handshake, and drives opmode and clock enables so the slice computes the sum (or negated sum) of products in P. Once the pipeline drains, it returns the 48-bit result on a valid/ready output. The block sits between an operand source (FIFO or memory reader) and one slice instance. The slice is configured with A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=CARRYOUTREG=1 and CARRYINSEL="OPMODE5".

## Interface
- LEN_W, 8, width of job length; max job = 2^LEN_W-1 pairs
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; accepted only in IDLE
- len  in  LEN_W  number of operand pairs, sampled with accepted start
- sub  in  1  0: P = Σ A·B; 1: P = −Σ A·B; sampled with accepted start
- busy  out  1  high in any state except IDLE
- in_valid / in_ready  in / out  1  operand handshake
- in_a, in_b  in  18  operands
- dsp_a, dsp_b  out  18  to slice A/B (combinational pass of in_a/in_b)
- dsp_cea, dsp_ceb  out  1  slice A/B enables = in_valid & in_ready
- dsp_cem  out  1  slice M enable = busy
- dsp_opmode  out  8  slice opmode
- dsp_ceopmode  out  1  slice opmode-register enable
- dsp_cep  out  1  slice P enable
- dsp_p  in  48  slice P
- dsp_carryout  in  1  slice registered CARRYOUT
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  48  registered result
- res_carry  out  1  OR of dsp_carryout over all accumulate cycles of the job

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with len≠0 → RUN; latch len and sub; clear issued count and res_carry.
  - start with len=0 → DONE with res_data=0 and res_carry=0; no slice enables asserted.
- RUN:
  - in_ready=1 while issued<len.
  - Each fire increments issued.
  - When the fire with issued=len−1 occurs → DRAIN.
- DRAIN: fixed 3-cycle countdown after the last fire, then capture dsp_p into res_data → DONE.
- DONE: res_valid=1 and res_data held stable until res_ready, then → IDLE.
- start is ignored when not in IDLE.
- Opmode per product: the first product of a job uses 0x01 (X=M, Z=0, add) when sub=0 or 0x81 when sub=1. Every later product uses 0x09 (X=M, Z=P, add) or 0x89 (P−M). Opmode bit 5 is always 0, so carry-in is 0.
- Operand bubbles (in_valid low during RUN) are legal. In bubble slots dsp_cep stays 0, so P is held.
- res_carry is the OR of dsp_carryout, sampled one cycle after each dsp_cep pulse.
- Arithmetic: 18x18 signed product sign-extended to 48 bits, accumulated mod 2^48. No saturation.
- Reset values: state=IDLE; busy, in_ready, dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, res_valid and res_carry = 0; dsp_opmode=0x00; res_data=0.
- Asserting rst_n low mid-job aborts the job immediately; in-flight products are discarded. The P left in the slice is don't-care, because the next job's first opmode clears the accumulation.

## Timing
- Operand fire in cycle t produces:
  - t+1: dsp_opmode = opmode for that product, dsp_ceopmode=1.
  - t+2: dsp_cep=1.
  - t+3: the updated P is visible on dsp_p.
- The controller keeps a 2-deep valid/first tag shift register to produce these signals. Outside tagged slots, dsp_ceopmode=0 and dsp_opmode holds its last value.
- Last fire at t_L:
  - res_data is captured at the end of t_L+3.
  - res_valid rises in t_L+4.
  - busy falls the cycle after the res_valid & res_ready handshake.
- Back-to-back fires sustain 1 product/cycle.
- Minimum job-to-job gap: a new start is accepted in the IDLE cycle following the result handshake.
- For len=0: res_valid is asserted the cycle after start.

## Test plan
- Reset: hold rst_n=0 → all outputs at their reset values; release → IDLE, busy=0.
- len=3, sub=0, pairs (2,3),(4,5),(−1,7), fired back-to-back from t=0 → dsp_opmode 0x01,0x09,0x09 in cycles 1–3; dsp_cep high in cycles 2–4; res_valid rises in cycle 6 with res_data=19.
- len=2, sub=1, pairs (10,10),(1,5), with a 2-cycle in_valid bubble between them → res_data=−105 (0xFFFF_FFFF_FF97); dsp_cep stays low during the bubble slots.
- len=0 → res_valid the cycle after start, res_data=0, no dsp_cea/dsp_cep pulses.
- res_ready held low for 5 cycles in DONE → res_data stable; start pulses ignored; busy=1.
- rst_n asserted low after the 2nd fire of a len=4 job → immediate IDLE. A following len=1 job with (3,3) returns 9.
